// File: rtl/ifetch_prefetch.sv
// Decoupled instruction fetch: a fetch PC drives a 1-cycle synchronous ROM, and returned words
// are tagged with their byte PC and queued for decode behind a valid/ready handshake.
module ifetch_prefetch #(
    parameter int          ADDR_W   = 14,
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       instruction,
    output logic [31:0]       inst_pc,
    output logic [31:0]       pc_plus_4,
    output logic              fetch_fault
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   QD_L   = QDEPTH[CW:0];
    localparam logic [CW-1:0] C_ONE  = 1;
    localparam logic [PW-1:0] P_ONE  = 1;

    logic [31:0]   fpc_r;
    logic          infl_r;
    logic [31:0]   infl_pc_r;
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          fault_r;
    logic [31:0]   q_word_r [QDEPTH];
    logic [31:0]   q_pc_r   [QDEPTH];

    logic          pop_s;
    logic          push_s;
    logic [CW:0]   occ_s;

    assign pop_s  = inst_valid & inst_ready;
    assign push_s = infl_r & ~redirect;
    // Occupancy after this edge if nothing new is issued; pop never exceeds count + infl.
    assign occ_s  = {1'b0, count_r} + {{CW{1'b0}}, infl_r} - {{CW{1'b0}}, pop_s};

    assign rom_addr    = fpc_r[ADDR_W+1:2];
    assign pc_plus_4   = inst_pc + 32'd4;
    assign fetch_fault = fault_r;

    // ROM issue strobe; inst_ready reaches here combinationally through pop_s.
    always_comb begin
        rom_en = 1'b0;
        if (!reset && !redirect && (occ_s < QD_L)) begin
            rom_en = 1'b1;
        end else begin
            rom_en = 1'b0;
        end
    end

    // Queue head presentation, zeroed when empty.
    always_comb begin
        inst_valid  = 1'b0;
        instruction = 32'd0;
        inst_pc     = 32'd0;
        if (count_r != {CW{1'b0}}) begin
            inst_valid  = 1'b1;
            instruction = q_word_r[head_r];
            inst_pc     = q_pc_r[head_r];
        end else begin
            inst_valid  = 1'b0;
            instruction = 32'd0;
            inst_pc     = 32'd0;
        end
    end

    // Fetch PC, in-flight tracking, queue pointers/count and the sticky fault flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fpc_r     <= RESET_PC;
            infl_r    <= 1'b0;
            infl_pc_r <= 32'd0;
            head_r    <= {PW{1'b0}};
            tail_r    <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            fault_r   <= 1'b0;
        end else if (redirect) begin
            // Flush; clearing infl discards the word still coming back from the ROM.
            fpc_r   <= {redirect_pc[31:2], 2'b00};
            infl_r  <= 1'b0;
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            if (redirect_pc[1:0] != 2'b00) begin
                fault_r <= 1'b1;
            end
        end else begin
            if (rom_en) begin
                fpc_r     <= fpc_r + 32'd4;
                infl_r    <= 1'b1;
                infl_pc_r <= fpc_r;
            end else begin
                infl_r    <= 1'b0;
            end
            if (push_s) begin
                tail_r <= tail_r + P_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + P_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + C_ONE;
                2'b01:   count_r <= count_r - C_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are only observed through count, so no reset is needed.
    always_ff @(posedge clock) begin
        if (push_s) begin
            q_word_r[tail_r] <= rom_data;
            q_pc_r[tail_r]   <= infl_pc_r;
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with a 16-word synchronous ROM whose word i reads C0DE_000i.
module tb_ifetch_prefetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        rom_en;
    logic [3:0]  rom_addr;
    logic [31:0] rom_data = 32'd0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus_4;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    ifetch_prefetch #(
        .ADDR_W   (4),
        .QDEPTH   (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .instruction (instruction),
        .inst_pc     (inst_pc),
        .pc_plus_4   (pc_plus_4),
        .fetch_fault (fetch_fault)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rom_en) begin
            rom_data <= 32'hC0DE_0000 | {28'd0, rom_addr};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'hC0DE_0000 | ((pc >> 2) & 32'h0000_000F);
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check_eq({tag, ".valid"}, {31'd0, inst_valid}, 32'd1);
        check_eq({tag, ".pc"},    inst_pc,             pc);
        check_eq({tag, ".inst"},  instruction,         word_at(pc));
        check_eq({tag, ".pc4"},   pc_plus_4,           pc + 32'd4);
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, ".valid"}, {31'd0, inst_valid}, 32'd0);
        check_eq({tag, ".inst"},  instruction,         32'd0);
        check_eq({tag, ".pc"},    inst_pc,             32'd0);
        check_eq({tag, ".pc4"},   pc_plus_4,           32'd4);
    endtask

    task automatic check_rom(input string tag, input logic en, input logic [3:0] addr);
        check_eq({tag, ".rom_en"}, {31'd0, rom_en}, {31'd0, en});
        if (en) begin
            check_eq({tag, ".rom_addr"}, {28'd0, rom_addr}, {28'd0, addr});
        end
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        inst_ready  = 1'b0;
        tick();
        tick();
        #1;
        check_rom("rst", 1'b0, 4'd0);
        check_empty("rst");
        check_eq("rst.fault", {31'd0, fetch_fault}, 32'd0);

        // Boot stream with decode always ready
        reset      = 1'b0;
        inst_ready = 1'b1;
        #1;
        check_rom("boot0", 1'b1, 4'd0);
        tick();
        #1;
        check_empty("boot1");
        check_rom("boot1", 1'b1, 4'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            #1;
            check_head("stream", 32'(4 * k));
        end

        // Backpressure: queue fills to 4 then fetch stops at the next unfetched word
        inst_ready = 1'b0;
        #1;
        check_rom("bp0", 1'b1, 4'd7);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        #1;
        check_rom("bp_full", 1'b0, 4'd0);
        check_eq("bp_full.addr", {28'd0, rom_addr}, 32'd9);
        check_head("bp_full", 32'd20);
        inst_ready = 1'b1;
        #1;
        check_rom("bp_release", 1'b1, 4'd9);
        for (int j = 1; j <= 6; j++) begin
            tick();
            #1;
            check_head("drain", 32'(20 + 4 * j));
        end

        // Redirect with 3 queued words and one in flight
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        inst_ready  = 1'b0;
        #1;
        check_rom("redir_cyc", 1'b0, 4'd0);
        tick();
        redirect   = 1'b0;
        inst_ready = 1'b1;
        #1;
        check_empty("redir_e0");
        check_rom("redir_e0", 1'b1, 4'd0);
        tick();
        #1;
        check_empty("redir_e1");
        tick();
        #1;
        check_head("redir_e2", 32'h0000_0100);
        tick();
        #1;
        check_head("redir_e3", 32'h0000_0104);

        // Redirect while popping, then an immediate second redirect
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0180;
        #1;
        check_eq("pop_redir.valid", {31'd0, inst_valid}, 32'd1);
        tick();
        redirect_pc = 32'h0000_0200;
        #1;
        check_empty("b2b_1");
        check_rom("b2b_1", 1'b0, 4'd0);
        tick();
        redirect = 1'b0;
        #1;
        check_empty("b2b_2");
        check_rom("b2b_2", 1'b1, 4'd0);
        tick();
        #1;
        check_empty("b2b_3");
        tick();
        #1;
        check_head("b2b_4", 32'h0000_0200);
        tick();
        #1;
        check_head("b2b_5", 32'h0000_0204);

        // Misaligned redirect target
        check_eq("fault_pre", {31'd0, fetch_fault}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0042;
        tick();
        redirect = 1'b0;
        #1;
        check_eq("fault_set", {31'd0, fetch_fault}, 32'd1);
        check_empty("mis_e0");
        tick();
        tick();
        #1;
        check_head("mis_e2", 32'h0000_0040);
        check_eq("fault_hold", {31'd0, fetch_fault}, 32'd1);

        // ROM address wrap at 16 words
        redirect    = 1'b1;
        redirect_pc = 32'h0000_003C;
        tick();
        redirect = 1'b0;
        #1;
        check_rom("wrap0", 1'b1, 4'd15);
        tick();
        #1;
        check_rom("wrap1", 1'b1, 4'd0);
        tick();
        #1;
        check_rom("wrap2", 1'b1, 4'd1);
        check_head("wrap2", 32'h0000_003C);
        tick();
        #1;
        check_head("wrap3", 32'h0000_0040);
        tick();
        #1;
        check_head("wrap4", 32'h0000_0044);
        check_eq("fault_sticky", {31'd0, fetch_fault}, 32'd1);

        // 32-bit PC wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        #1;
        check_head("pc32_top", 32'hFFFF_FFFC);
        tick();
        #1;
        check_head("pc32_wrap", 32'h0000_0000);

        // Asynchronous reset mid-stream
        check_rom("areset_pre", 1'b1, 4'd2);
        reset = 1'b1;
        #1;
        check_eq("areset.rom_en", {31'd0, rom_en}, 32'd0);
        check_empty("areset");
        check_eq("areset.fault", {31'd0, fetch_fault}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_rom("restart0", 1'b1, 4'd0);
        tick();
        #1;
        check_empty("restart1");
        tick();
        #1;
        check_head("restart2", 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch_prefetch.md
# ifetch_prefetch

Parametrised instruction-fetch unit for the 31-instruction MIPS core. It replaces the single-PC fetch stage with a decoupled design:
- a fetch PC drives a synchronous instruction ROM;
- returned words are tagged with their byte PC and held in a small prefetch queue;
- decode consumes them through a valid/ready handshake.

All control-flow changes (beq/bne/j/jal/jr) arrive as a single resolved redirect, which flushes queued and in-flight words.

## Interface
Parameters:
- ADDR_W, 14, ROM word-address width (ROM holds 2^ADDR_W words).
- QDEPTH, 4, prefetch queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, byte PC fetched after reset; word aligned.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- rom_en  output  1  ROM read strobe for this cycle.
- rom_addr  output  ADDR_W  word address, equal to fpc[ADDR_W+1:2].
- rom_data  input  32  ROM word; valid the cycle after rom_en (1-cycle synchronous ROM).
- redirect  input  1  control-flow change, resolved downstream.
- redirect_pc  input  32  byte-address target.
- inst_valid  output  1  queue head is valid.
- inst_ready  input  1  decode accepts the head this cycle.
- instruction  output  32  queue head word; 0 when the queue is empty.
- inst_pc  output  32  byte PC of the head; 0 when the queue is empty.
- pc_plus_4  output  32  inst_pc + 4; link value for jal. This is a full byte address, not shifted.
- fetch_fault  output  1  sticky: a misaligned redirect target has been seen.

## Operation
- State:
  - fetch PC fpc (32 bits);
  - in-flight flag infl, plus the tag register infl_pc;
  - circular queue of {word, pc} with head and tail pointers and a count of 0..QDEPTH;
  - fetch_fault.
- Reset values:
  - fpc = RESET_PC; infl = 0; count = 0; pointers = 0; fetch_fault = 0.
  - Outputs: inst_valid = 0, instruction = 0, inst_pc = 0, pc_plus_4 = 4, rom_en = 0.
- pop = inst_valid & inst_ready.
- Issue condition: rom_en = !reset & !redirect & (count + infl − pop < QDEPTH).
  - This gives a combinational path from inst_ready to rom_en; this path is intended.
- On issue:
  - fpc ← fpc + 4;
  - infl ← 1, infl_pc ← fpc;
  - otherwise infl ← 0.
- Return: if infl was set in the previous cycle and no redirect is sampled this edge, push {rom_data, infl_pc} at the tail.
  - Space is guaranteed by the issue condition, so a push is never dropped.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Redirect (sampled at an edge):
  - count ← 0; head = tail ← 0; infl ← 0, so the word arriving next cycle is discarded;
  - fpc ← {redirect_pc[31:2], 2'b00};
  - if redirect_pc[1:0] ≠ 0, fetch_fault ← 1. It is cleared only by reset.
- Redirect with simultaneous pop: the popped head counts as accepted by decode. The remaining entries are discarded, and redirect wins over the push.
- Address wrap: rom_addr takes only fpc[ADDR_W+1:2], so fetch wraps modulo the ROM size. inst_pc keeps the full 32-bit value.
- fpc arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- After reset deasserts:
  - the first rom_en is in cycle 0 (RESET_PC);
  - inst_valid rises after the 2nd edge (issue edge, then push edge).
- Redirect at edge E0:
  - the cycle after E0 has rom_en = 1 with addr = redirect_pc;
  - push at E2; inst_valid with inst_pc = redirect_pc from E2.
  - Redirect-to-valid latency is 2 cycles, with no bypass.
- Sustained throughput is 1 instruction per cycle with inst_ready held high, for any QDEPTH ≥ 2.
- With inst_ready low:
  - the queue fills to QDEPTH, then rom_en stays 0;
  - fpc points to the next unfetched word, and no word is lost or duplicated.
- Reset asserted mid-operation:
  - state clears asynchronously and rom_en falls in the same cycle;
  - any in-flight ROM word is ignored.
- Outputs instruction, inst_pc, pc_plus_4 and inst_valid come from registers and the queue head. They carry no combinational path from rom_data.

## Test plan
- Reset then inst_ready = 1, with the ROM word at each address equal to its word index:
  - inst_valid rises after 2 edges;
  - inst_pc runs 0, 4, 8, … on consecutive cycles;
  - instruction runs 0, 1, 2, …; pc_plus_4 = inst_pc + 4.
- Backpressure: inst_ready = 0 for 10 cycles, QDEPTH = 4:
  - count saturates at 4 and rom_en stays 0;
  - releasing inst_ready yields pcs 0, 4, 8, 12, 16, … with no gap and no repeat.
- Redirect to 32'h0000_0100 while the queue holds 3 entries and a word is in flight:
  - no stale word is delivered;
  - the next delivered inst_pc is 0x100 exactly 2 cycles later.
- Redirect with pop in the same cycle, then a back-to-back second redirect to 0x200:
  - only the popped word and then the word at 0x200 are delivered;
  - the first target is never delivered.
- Misaligned redirect 32'h0000_0042:
  - fetch_fault = 1 and stays high;
  - the fetch resumes at 0x40.
- Wrap: ADDR_W = 4, redirect to 0x3C:
  - rom_addr sequence is 15, 0, 1;
  - inst_pc sequence is 0x3C, 0x40, 0x44.
- Async reset mid-stream: rom_en and inst_valid drop without waiting for an edge, and fetch restarts at RESET_PC.
